// File: rtl/decode_stage_if.sv
// Bundle between IF/ID, register file, writeback, EX and the decode stage.
// The master modport is the surrounding pipeline; the slave modport is decode_stage.
interface decode_stage_if;
    // IF/ID side
    logic [31:0] instruction;
    logic        instrValid;
    logic        flush;
    logic        stall;

    // Register file read port
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;

    // Writeback port mirror
    logic        wbWrite;
    logic [4:0]  wbReg;
    logic [31:0] wbData;

    // Current ID/EX occupant, for load-use detection
    logic        exMemRead;
    logic [4:0]  exWriteReg;

    // Registered ID/EX outputs
    logic        idValid;
    logic [31:0] idData1;
    logic [31:0] idData2;
    logic [31:0] idImm;
    logic [4:0]  idDest;
    logic        idRegWrite;
    logic        idMemRead;
    logic        idMemWrite;
    logic        idAluSrc;
    logic        idBranch;
    logic [3:0]  idAluCtl;
    logic        idIllegal;

    modport master (
        output instruction, instrValid, flush, readData1, readData2,
        output wbWrite, wbReg, wbData, exMemRead, exWriteReg,
        input  stall, readReg1, readReg2,
        input  idValid, idData1, idData2, idImm, idDest, idRegWrite, idMemRead,
        input  idMemWrite, idAluSrc, idBranch, idAluCtl, idIllegal
    );

    modport slave (
        input  instruction, instrValid, flush, readData1, readData2,
        input  wbWrite, wbReg, wbData, exMemRead, exWriteReg,
        output stall, readReg1, readReg2,
        output idValid, idData1, idData2, idImm, idDest, idRegWrite, idMemRead,
        output idMemWrite, idAluSrc, idBranch, idAluCtl, idIllegal
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS-subset instruction decode stage with load-use stall and ID/EX register.
// Optional feature: define DECODE_WB_BYPASS_EN to forward the writeback port into
// idData1/idData2 when it targets rs/rt in the same cycle.
module decode_stage (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    localparam logic [3:0] AluAnd = 4'd0;
    localparam logic [3:0] AluOr  = 4'd1;
    localparam logic [3:0] AluAdd = 4'd2;
    localparam logic [3:0] AluSll = 4'd3;
    localparam logic [3:0] AluSrl = 4'd4;
    localparam logic [3:0] AluLui = 4'd5;
    localparam logic [3:0] AluSub = 4'd6;
    localparam logic [3:0] AluSlt = 4'd7;

    typedef enum logic [1:0] {ImmNone, ImmSign, ImmZero} imm_kind_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic [3:0]  alu_ctl;
        logic        illegal;
    } idex_t;

    localparam idex_t Bubble = '0;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    logic        dec_legal;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_alu_src;
    logic        dec_branch;
    logic [3:0]  dec_alu_ctl;
    logic [4:0]  dec_dest;
    logic        rt_used;
    imm_kind_e   imm_kind;
    logic [31:0] imm_ext;

    logic [31:0] src1;
    logic [31:0] src2;
    logic        hazard;
    logic        load_insn;

    idex_t       idex_d;
    idex_t       idex_q;

    assign opcode = bus.instruction[31:26];
    assign rs     = bus.instruction[25:21];
    assign rt     = bus.instruction[20:16];
    assign rd     = bus.instruction[15:11];
    assign funct  = bus.instruction[5:0];

    assign bus.readReg1 = rs;
    assign bus.readReg2 = rt;

    // Opcode/funct decode into control bits, destination and immediate kind
    always_comb begin
        dec_legal     = 1'b1;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_alu_src   = 1'b0;
        dec_branch    = 1'b0;
        dec_alu_ctl   = AluAnd;
        dec_dest      = 5'd0;
        rt_used       = 1'b0;
        imm_kind      = ImmNone;
        unique case (opcode)
            6'h00: begin
                dec_reg_write = 1'b1;
                dec_dest      = rd;
                rt_used       = 1'b1;
                unique case (funct)
                    6'h20:   dec_alu_ctl = AluAdd;
                    6'h22:   dec_alu_ctl = AluSub;
                    6'h24:   dec_alu_ctl = AluAnd;
                    6'h25:   dec_alu_ctl = AluOr;
                    6'h2A:   dec_alu_ctl = AluSlt;
                    6'h00:   dec_alu_ctl = AluSll;
                    6'h02:   dec_alu_ctl = AluSrl;
                    default: dec_legal   = 1'b0;
                endcase
            end
            6'h23: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctl   = AluAdd;
                dec_dest      = rt;
                imm_kind      = ImmSign;
            end
            6'h2B: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctl   = AluAdd;
                rt_used       = 1'b1;
                imm_kind      = ImmSign;
            end
            6'h04: begin
                dec_branch    = 1'b1;
                dec_alu_ctl   = AluSub;
                rt_used       = 1'b1;
                imm_kind      = ImmSign;
            end
            6'h08, 6'h0A: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctl   = (opcode == 6'h08) ? AluAdd : AluSlt;
                dec_dest      = rt;
                imm_kind      = ImmSign;
            end
            6'h0C, 6'h0D, 6'h0F: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctl   = (opcode == 6'h0C) ? AluAnd :
                                (opcode == 6'h0D) ? AluOr : AluLui;
                dec_dest      = rt;
                imm_kind      = ImmZero;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Immediate extension; R-type carries no immediate
    always_comb begin
        imm_ext = 32'd0;
        unique case (imm_kind)
            ImmSign: imm_ext = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
            ImmZero: imm_ext = {16'd0, bus.instruction[15:0]};
            default: imm_ext = 32'd0;
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    // Writeback in flight this cycle overrides the stale register file value
    always_comb begin
        src1 = bus.readData1;
        src2 = bus.readData2;
        if (bus.wbWrite && (bus.wbReg != 5'd0) && (bus.wbReg == rs)) begin
            src1 = bus.wbData;
        end
        if (bus.wbWrite && (bus.wbReg != 5'd0) && (bus.wbReg == rt)) begin
            src2 = bus.wbData;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wbWrite, bus.wbReg, bus.wbData};

    // Operands straight from the register file
    always_comb begin
        src1 = bus.readData1;
        src2 = bus.readData2;
    end
`endif

    // Load-use hazard; flush and reset both mask it since the slot is discarded
    always_comb begin
        hazard = bus.exMemRead && (bus.exWriteReg != 5'd0) &&
                 ((bus.exWriteReg == rs) || (rt_used && (bus.exWriteReg == rt)));
        bus.stall = rst_n && bus.instrValid && !bus.flush && hazard;
    end

    assign load_insn = bus.instrValid && !bus.flush && !bus.stall;

    // Next ID/EX contents: bubble unless a legal instruction issues this edge
    always_comb begin
        idex_d = Bubble;
        if (load_insn && !dec_legal) begin
            idex_d.illegal = 1'b1;
        end else if (load_insn) begin
            idex_d.valid     = 1'b1;
            idex_d.data1     = (rs == 5'd0) ? 32'd0 : src1;
            idex_d.data2     = (rt == 5'd0) ? 32'd0 : src2;
            idex_d.imm       = imm_ext;
            idex_d.dest      = dec_dest;
            idex_d.reg_write = dec_reg_write;
            idex_d.mem_read  = dec_mem_read;
            idex_d.mem_write = dec_mem_write;
            idex_d.alu_src   = dec_alu_src;
            idex_d.branch    = dec_branch;
            idex_d.alu_ctl   = dec_alu_ctl;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= Bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.idValid    = idex_q.valid;
    assign bus.idData1    = idex_q.data1;
    assign bus.idData2    = idex_q.data2;
    assign bus.idImm      = idex_q.imm;
    assign bus.idDest     = idex_q.dest;
    assign bus.idRegWrite = idex_q.reg_write;
    assign bus.idMemRead  = idex_q.mem_read;
    assign bus.idMemWrite = idex_q.mem_write;
    assign bus.idAluSrc   = idex_q.alu_src;
    assign bus.idBranch   = idex_q.branch;
    assign bus.idAluCtl   = idex_q.alu_ctl;
    assign bus.idIllegal  = idex_q.illegal;

endmodule
